// File: rtl/hist_eq_pkg.sv
// rtl/hist_eq_pkg.sv - shared bank lifecycle type and default sizes for the histogram-equalisation pipeline
package hist_eq_pkg;

    localparam int DEFAULT_PIXEL_COUNT = 307200;
    localparam int DEFAULT_CDF_W       = 20;

    typedef enum logic [1:0] {
        EMPTY      = 2'd0,
        HIST_READY = 2'd1,
        CDF_READY  = 2'd2
    } bank_state_t;

endpackage

// File: rtl/hist_bank_slot.sv
// rtl/hist_bank_slot.sv - one ping-pong histogram bank: lifecycle state, latched cdf_min and clamped divisor
module hist_bank_slot
    import hist_eq_pkg::*;
#(
    parameter int PIXEL_COUNT = DEFAULT_PIXEL_COUNT,
    parameter int CDF_W       = DEFAULT_CDF_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             markHist,
    input  logic             markCdf,
    input  logic             markFree,
    input  logic [CDF_W-1:0] cdfMin,
    output bank_state_t      state,
    output logic [CDF_W-1:0] bankMin,
    output logic [CDF_W-1:0] bankDiv
);

    localparam logic [CDF_W-1:0] PIX = CDF_W'(PIXEL_COUNT);

    bank_state_t      stateNext;
    logic [CDF_W-1:0] divNext;

    // Advance the bank only on the strobe that matches its current lifecycle step
    always_comb begin
        stateNext = state;
        case (state)
            EMPTY:      if (markHist) stateNext = HIST_READY;
            HIST_READY: if (markCdf)  stateNext = CDF_READY;
            CDF_READY:  if (markFree) stateNext = EMPTY;
            default:    stateNext = EMPTY;
        endcase
    end

    // Clamp so a degenerate frame (every pixel at cdf_min) never yields a zero divisor
    always_comb begin
        divNext = PIX - cdfMin;
        if (cdfMin >= PIX) begin
            divNext = CDF_W'(1);
        end
    end

    // Bank lifecycle state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // Capture cdf_min and divisor when the CDF engine finishes this bank
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bankMin <= '0;
            bankDiv <= CDF_W'(1);
        end else if (markCdf && (state == HIST_READY)) begin
            bankMin <= cdfMin;
            bankDiv <= divNext;
        end
    end

endmodule

// File: rtl/hist_frame_scheduler.sv
// rtl/hist_frame_scheduler.sv - ping-pong frame scheduler for input/CDF/output engines; SCHED_PERF_CNT_EN adds stall counters
module hist_frame_scheduler
    import hist_eq_pkg::*;
#(
    parameter int PIXEL_COUNT = DEFAULT_PIXEL_COUNT,
    parameter int CDF_W       = DEFAULT_CDF_W,
    parameter int PEND_W      = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    output logic             input_start,
    input  logic             input_done,
    output logic             cdf_start,
    input  logic             cdf_done,
    input  logic             cdf_valid,
    input  logic [CDF_W-1:0] Cdf_Min,
    output logic             output_start,
    input  logic             output_done,
    output logic             input_base_offset,
    output logic             cdf_base_offset,
    output logic             output_base_offset,
    output logic [CDF_W-1:0] Cdf_Min_Out,
    output logic [CDF_W-1:0] Divisor,
    output logic             busy,
    output logic             protocol_error,
`ifdef SCHED_PERF_CNT_EN
    output logic [15:0]      stall_in_cnt,
    output logic [15:0]      stall_out_cnt,
`endif
    output logic             start_overflow
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    bank_state_t      bankState [2];
    logic [CDF_W-1:0] bankMin   [2];
    logic [CDF_W-1:0] bankDiv   [2];

    logic [1:0]        markHist, markCdf, markFree;
    logic [CDF_W-1:0]  cdfMinEff;
    logic              inBusy, cdfBusy, outBusy;
    logic              inPtr, cdfPtr, outPtr;
    logic [PEND_W-1:0] pending, pendingNext;
    logic              pendingFull;
    logic              launchIn, launchCdf, launchOut;
    logic              inDoneOk, cdfDoneOk, outDoneOk;
    logic              protocolErrNow;

    // Launch decisions look only at registered state, giving a one-cycle bubble after each done
    always_comb begin
        pendingFull = (pending == PEND_MAX);
        launchIn    = (pending != '0) && !inBusy && (bankState[inPtr] == EMPTY);
        launchCdf   = !cdfBusy && (bankState[cdfPtr] == HIST_READY);
        launchOut   = !outBusy && (bankState[outPtr] == CDF_READY);
        inDoneOk    = input_done && inBusy;
        cdfDoneOk   = cdf_done && cdfBusy;
        outDoneOk   = output_done && outBusy;
        cdfMinEff   = cdf_valid ? Cdf_Min : '0;
    end

    // Route accepted done pulses to the bank currently owned by that stage
    always_comb begin
        markHist = '0;
        markCdf  = '0;
        markFree = '0;
        if (inDoneOk)  markHist[inPtr]  = 1'b1;
        if (cdfDoneOk) markCdf[cdfPtr]  = 1'b1;
        if (outDoneOk) markFree[outPtr] = 1'b1;
    end

    for (genvar b = 0; b < 2; b++) begin : gSlot
        hist_bank_slot #(
            .PIXEL_COUNT (PIXEL_COUNT),
            .CDF_W       (CDF_W)
        ) uSlot (
            .clock    (clock),
            .reset_n  (reset_n),
            .markHist (markHist[b]),
            .markCdf  (markCdf[b]),
            .markFree (markFree[b]),
            .cdfMin   (cdfMinEff),
            .state    (bankState[b]),
            .bankMin  (bankMin[b]),
            .bankDiv  (bankDiv[b])
        );
    end

    // Frame requests accumulate until the input engine consumes them; excess requests are dropped
    always_comb begin
        pendingNext = pending;
        if (start && !pendingFull) pendingNext = pendingNext + PEND_W'(1);
        if (launchIn)              pendingNext = pendingNext - PEND_W'(1);
    end

    // Start pulses, engine busy flags, held bank offsets and stage pointers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            input_start        <= 1'b0;
            cdf_start          <= 1'b0;
            output_start       <= 1'b0;
            inBusy             <= 1'b0;
            cdfBusy            <= 1'b0;
            outBusy            <= 1'b0;
            inPtr              <= 1'b0;
            cdfPtr             <= 1'b0;
            outPtr             <= 1'b0;
            input_base_offset  <= 1'b0;
            cdf_base_offset    <= 1'b0;
            output_base_offset <= 1'b0;
        end else begin
            input_start  <= launchIn;
            cdf_start    <= launchCdf;
            output_start <= launchOut;
            if (launchIn) begin
                inBusy            <= 1'b1;
                input_base_offset <= inPtr;
            end else if (inDoneOk) begin
                inBusy <= 1'b0;
                inPtr  <= ~inPtr;
            end
            if (launchCdf) begin
                cdfBusy         <= 1'b1;
                cdf_base_offset <= cdfPtr;
            end else if (cdfDoneOk) begin
                cdfBusy <= 1'b0;
                cdfPtr  <= ~cdfPtr;
            end
            if (launchOut) begin
                outBusy            <= 1'b1;
                output_base_offset <= outPtr;
            end else if (outDoneOk) begin
                outBusy <= 1'b0;
                outPtr  <= ~outPtr;
            end
        end
    end

    // Output-stage cdf_min and divisor follow the bank being launched and hold until the next launch
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            Cdf_Min_Out <= '0;
            Divisor     <= CDF_W'(1);
        end else if (launchOut) begin
            Cdf_Min_Out <= bankMin[outPtr];
            Divisor     <= bankDiv[outPtr];
        end
    end

    // Pending frame request counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= pendingNext;
        end
    end

    // Any stray done or an unqualified cdf_min is latched as a protocol error
    always_comb begin
        protocolErrNow = (input_done && !inBusy) || (cdf_done && !cdfBusy) ||
                         (output_done && !outBusy) || (cdfDoneOk && !cdf_valid);
    end

    // Sticky error and overflow flags
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            protocol_error <= 1'b0;
            start_overflow <= 1'b0;
        end else begin
            if (protocolErrNow)       protocol_error <= 1'b1;
            if (start && pendingFull) start_overflow <= 1'b1;
        end
    end

    // Scheduler is busy while any frame is queued, in flight or parked in a bank
    always_comb begin
        busy = (pending != '0) || inBusy || cdfBusy || outBusy ||
               (bankState[0] != EMPTY) || (bankState[1] != EMPTY);
    end

`ifdef SCHED_PERF_CNT_EN
    logic stallIn, stallOut;

    // Stall conditions: queued frame blocked by an occupied bank, output idle while work exists
    always_comb begin
        stallIn  = (pending != '0) && !inBusy && (bankState[inPtr] != EMPTY);
        stallOut = !outBusy && busy;
    end

    // Saturating stall counters
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_in_cnt  <= '0;
            stall_out_cnt <= '0;
        end else begin
            if (stallIn && (stall_in_cnt != 16'hFFFF))   stall_in_cnt  <= stall_in_cnt + 16'd1;
            if (stallOut && (stall_out_cnt != 16'hFFFF)) stall_out_cnt <= stall_out_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hist_frame_scheduler.sv
// tb/tb_hist_frame_scheduler.sv - scoreboard bench for hist_frame_scheduler with modelled engines
module tb_hist_frame_scheduler;

    localparam int CDF_W   = 20;
    localparam int ENG_LAT = 10;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic             input_start, input_done;
    logic             cdf_start, cdf_done, cdf_valid;
    logic [CDF_W-1:0] Cdf_Min;
    logic             output_start, output_done;
    logic             input_base_offset, cdf_base_offset, output_base_offset;
    logic [CDF_W-1:0] Cdf_Min_Out, Divisor;
    logic             busy, protocol_error, start_overflow;
`ifdef SCHED_PERF_CNT_EN
    logic [15:0]      stall_in_cnt, stall_out_cnt;
`endif

    hist_frame_scheduler #(
        .PIXEL_COUNT (307200),
        .CDF_W       (CDF_W),
        .PEND_W      (3)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .start              (start),
        .input_start        (input_start),
        .input_done         (input_done),
        .cdf_start          (cdf_start),
        .cdf_done           (cdf_done),
        .cdf_valid          (cdf_valid),
        .Cdf_Min            (Cdf_Min),
        .output_start       (output_start),
        .output_done        (output_done),
        .input_base_offset  (input_base_offset),
        .cdf_base_offset    (cdf_base_offset),
        .output_base_offset (output_base_offset),
        .Cdf_Min_Out        (Cdf_Min_Out),
        .Divisor            (Divisor),
        .busy               (busy),
        .protocol_error     (protocol_error),
`ifdef SCHED_PERF_CNT_EN
        .stall_in_cnt       (stall_in_cnt),
        .stall_out_cnt      (stall_out_cnt),
`endif
        .start_overflow     (start_overflow)
    );

    int tests    = 0;
    int failures = 0;
    int epoch    = 0;
    int strayReq = 0;
    int outDoneCnt = 0;
    bit hold [3];
    bit nextBank;

    bit               expIn  [$];
    bit               expCdf [$];
    bit               expOut [$];
    logic [CDF_W-1:0] expMinQ[$];
    logic [CDF_W-1:0] expDivQ[$];
    logic [CDF_W:0]   cdfVals[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit, expected $finish earlier");
        $fatal(1);
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic waitFor(input int which, input int maxCyc, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < maxCyc && !hit; i++) begin
            step();
            case (which)
                0:       hit = input_start;
                1:       hit = cdf_start;
                2:       hit = output_start;
                3:       hit = input_done;
                4:       hit = output_done;
                default: hit = !busy;
            endcase
        end
        tests++;
        if (!hit) begin
            failures++;
            $display("FAIL %s: got timeout after %0d cycles, expected event", name, maxCyc);
        end
    endtask

    // Engine delay with optional hold; aborts when a reset bumps the epoch
    task automatic engWait(input int which, input int ep, output bit ok);
        int cnt;
        cnt = 1;
        ok  = 1'b1;
        while (cnt < ENG_LAT || hold[which]) begin
            @(negedge clock);
            if (ep != epoch) begin
                ok = 1'b0;
                return;
            end
            cnt++;
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic issueFrame(input logic [CDF_W-1:0] m, input bit v,
                              input logic [CDF_W-1:0] expMin, input logic [CDF_W-1:0] expDiv);
        expIn.push_back(nextBank);
        expCdf.push_back(nextBank);
        expOut.push_back(nextBank);
        expMinQ.push_back(expMin);
        expDivQ.push_back(expDiv);
        cdfVals.push_back({v, m});
        nextBank = ~nextBank;
        pulseStart();
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        epoch++;
        expIn.delete();
        expCdf.delete();
        expOut.delete();
        expMinQ.delete();
        expDivQ.delete();
        cdfVals.delete();
        nextBank = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic checkResetState(input string tag);
        check({tag, " input_start"}, input_start, 0);
        check({tag, " cdf_start"}, cdf_start, 0);
        check({tag, " output_start"}, output_start, 0);
        check({tag, " input_base_offset"}, input_base_offset, 0);
        check({tag, " cdf_base_offset"}, cdf_base_offset, 0);
        check({tag, " output_base_offset"}, output_base_offset, 0);
        check({tag, " Cdf_Min_Out"}, Cdf_Min_Out, 0);
        check({tag, " Divisor"}, Divisor, 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " protocol_error"}, protocol_error, 0);
        check({tag, " start_overflow"}, start_overflow, 0);
    endtask

    // Input engine model
    initial begin : engIn
        int ep;
        bit ok;
        input_done = 1'b0;
        forever begin
            @(negedge clock);
            input_done = 1'b0;
            if (input_start) begin
                ep = epoch;
                engWait(0, ep, ok);
                if (ok) input_done = 1'b1;
            end
        end
    end

    // CDF engine model: presents the frame's cdf_min and qualifier with its done pulse
    initial begin : engCdf
        int ep;
        bit ok;
        cdf_done  = 1'b0;
        cdf_valid = 1'b0;
        Cdf_Min   = '0;
        forever begin
            @(negedge clock);
            cdf_done = 1'b0;
            if (cdf_start) begin
                ep = epoch;
                engWait(1, ep, ok);
                if (ok) begin
                    if (cdfVals.size() > 0) {cdf_valid, Cdf_Min} = cdfVals.pop_front();
                    else {cdf_valid, Cdf_Min} = {1'b1, 20'd0};
                    cdf_done = 1'b1;
                end
            end
        end
    end

    // Output engine model, also able to emit an unsolicited done
    initial begin : engOut
        int ep;
        int strayAck;
        bit ok;
        strayAck    = 0;
        output_done = 1'b0;
        forever begin
            @(negedge clock);
            output_done = 1'b0;
            if (strayAck != strayReq) begin
                strayAck++;
                output_done = 1'b1;
            end else if (output_start) begin
                ep = epoch;
                engWait(2, ep, ok);
                if (ok) begin
                    output_done = 1'b1;
                    outDoneCnt++;
                end
            end
        end
    end

    // Scoreboard monitor: every launch pulse is matched against the oldest expected frame
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (input_start) begin
                if (expIn.size() == 0) check("unexpected input_start", 1, 0);
                else check("input_base_offset", input_base_offset, expIn.pop_front());
            end
            if (cdf_start) begin
                if (expCdf.size() == 0) check("unexpected cdf_start", 1, 0);
                else check("cdf_base_offset", cdf_base_offset, expCdf.pop_front());
            end
            if (output_start) begin
                if (expOut.size() == 0) check("unexpected output_start", 1, 0);
                else begin
                    check("output_base_offset", output_base_offset, expOut.pop_front());
                    check("Cdf_Min_Out", Cdf_Min_Out, expMinQ.pop_front());
                    check("Divisor", Divisor, expDivQ.pop_front());
                end
            end
        end
    end

    initial begin : mainSeq
        int outBase;
`ifdef SCHED_PERF_CNT_EN
        logic [15:0] sa, sb;
`endif
        reset_n  = 1'b0;
        start    = 1'b0;
        nextBank = 1'b0;
        for (int i = 0; i < 3; i++) hold[i] = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        checkResetState("reset");

        // Single frame through all three engines
        issueFrame(20'd100, 1'b1, 20'd100, 20'd307100);
        waitFor(4, 100, "t1 output_done");
        check("t1 busy during output_done", busy, 1);
        step();
        check("t1 busy after output_done", busy, 0);

        // Three back-to-back frames, ping-pong banks 0,1,0
        doReset();
        outBase = outDoneCnt;
        issueFrame(20'd100, 1'b1, 20'd100, 20'd307100);
        issueFrame(20'd2000, 1'b1, 20'd2000, 20'd305200);
        issueFrame(20'd50000, 1'b1, 20'd50000, 20'd257200);
        waitFor(3, 100, "t2 first input_done");
        step();
        check("t2 bubble after input_done", input_start, 0);
        step();
        check("t2 frame2 input_start", input_start, 1);
        check("t2 frame2 input offset", input_base_offset, 1);
        waitFor(0, 100, "t2 frame3 input_start");
        check("t2 frame3 waits for output_done", outDoneCnt - outBase, 1);
        check("t2 frame3 input offset", input_base_offset, 0);
        waitFor(5, 200, "t2 idle");

        // Divisor clamp and unqualified cdf_min
        check("t3 protocol_error clear", protocol_error, 0);
        issueFrame(20'd307200, 1'b1, 20'd307200, 20'd1);
        issueFrame(20'd0, 1'b0, 20'd0, 20'd307200);
        waitFor(5, 200, "t3 idle");
        check("t3 protocol_error after invalid cdf", protocol_error, 1);

        // Stray done and pending saturation
        doReset();
        checkResetState("t4 reset");
        strayReq++;
        waitFor(4, 10, "t4 stray output_done");
        step();
        check("t4 protocol_error on stray done", protocol_error, 1);
        check("t4 busy unchanged by stray done", busy, 0);
        hold[0] = 1'b1;
        issueFrame(20'd1, 1'b1, 20'd1, 20'd307199);
        waitFor(0, 10, "t4 held input launch");
        for (int i = 0; i < 7; i++) pulseStart();
        check("t4 no overflow at 7 pending", start_overflow, 0);
        pulseStart();
        check("t4 overflow at 8th request", start_overflow, 1);
        check("t4 busy while pending", busy, 1);
        doReset();
        hold[0] = 1'b0;

        // Reset while CDF works on bank 1, then restart from bank 0
        issueFrame(20'd300, 1'b1, 20'd300, 20'd306900);
        issueFrame(20'd400, 1'b1, 20'd400, 20'd306800);
        waitFor(1, 50, "t5 first cdf_start");
        waitFor(1, 50, "t5 second cdf_start");
        check("t5 cdf offset before reset", cdf_base_offset, 1);
        repeat (3) step();
        doReset();
        checkResetState("t5 reset mid-cdf");
        issueFrame(20'd7, 1'b1, 20'd7, 20'd307193);
        waitFor(5, 100, "t5 restart idle");

`ifdef SCHED_PERF_CNT_EN
        // Stall counters with the output engine parked on bank 0
        doReset();
        check("perf stall_in after reset", stall_in_cnt, 0);
        check("perf stall_out after reset", stall_out_cnt, 0);
        issueFrame(20'd11, 1'b1, 20'd11, 20'd307189);
        issueFrame(20'd12, 1'b1, 20'd12, 20'd307188);
        issueFrame(20'd13, 1'b1, 20'd13, 20'd307187);
        waitFor(0, 20, "perf first input_start");
        sa = stall_out_cnt;
        sb = stall_in_cnt;
        repeat (5) step();
        check("perf stall_out during input", stall_out_cnt - sa, 5);
        check("perf stall_in while input busy", stall_in_cnt - sb, 0);
        hold[2] = 1'b1;
        waitFor(2, 50, "perf first output_start");
        repeat (15) step();
        sa = stall_out_cnt;
        sb = stall_in_cnt;
        repeat (20) step();
        check("perf stall_in while bank blocked", stall_in_cnt - sb, 20);
        check("perf stall_out while output held", stall_out_cnt - sa, 0);
        hold[2] = 1'b0;
        waitFor(5, 300, "perf idle");
`endif

        check("scoreboard input drained", expIn.size(), 0);
        check("scoreboard cdf drained", expCdf.size(), 0);
        check("scoreboard output drained", expOut.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
